// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked unsigned add/sub/mul/div with registered results.
// ADD, SUB, MUL and divide-by-zero complete on the accept edge; a real divide
// runs a restoring divider that resolves one quotient bit per edge, MSB first.
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  localparam int CW = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_cnt;        // index of the last completed divide iteration
  logic [WIDTH-1:0]     r_rem;        // partial remainder
  logic [WIDTH-1:0]     r_quot;       // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]     r_divisor;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_remainder;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_div_start;
  logic                 w_calc_last;

  // Single-cycle operation results
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_fast_result;
  logic [WIDTH-1:0]     w_fast_rem;
  logic                 w_fast_dbz;

  // One restoring-division step
  logic [WIDTH-1:0]     w_it_rem_in;
  logic [WIDTH-1:0]     w_it_quot_in;
  logic [WIDTH-1:0]     w_it_div;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quot_next;

  assign w_accept    = in_valid && in_ready;
  assign w_div_start = w_accept && (op_t'(op) == OP_DIV) && (b != '0);
  assign w_calc_last = (r_state == S_CALC) && (r_cnt == CW'(WIDTH - 2));

  // The first quotient bit is resolved on the accept edge straight from the
  // operand inputs, so a divide leaves CALC after WIDTH-1 further edges.
  assign w_it_rem_in  = (r_state == S_IDLE) ? '0 : r_rem;
  assign w_it_quot_in = (r_state == S_IDLE) ? a  : r_quot;
  assign w_it_div     = (r_state == S_IDLE) ? b  : r_divisor;

  assign w_shift     = {w_it_rem_in, w_it_quot_in[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, w_it_div};
  // The partial remainder stays below the divisor, so the borrow out of the
  // (WIDTH+1)-bit trial subtraction is exactly "shifted remainder < divisor".
  assign w_ge        = ~w_trial[WIDTH];
  assign w_rem_next  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_next = {w_it_quot_in[WIDTH-2:0], w_ge};

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Select the result of an op that completes on its accept edge
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    w_fast_result = '0;
    w_fast_rem    = '0;
    w_fast_dbz    = 1'b0;
    case (op_t'(op))
      OP_ADD: w_fast_result = {{(WIDTH-1){1'b0}}, w_sum};
      OP_SUB: w_fast_result = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
      OP_MUL: w_fast_result = w_prod;
      OP_DIV: begin
        w_fast_result = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        w_fast_rem    = a;
        w_fast_dbz    = 1'b1;
      end
      default: w_fast_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = w_div_start ? S_CALC : S_DONE;
      S_CALC:  if (w_calc_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !rst;
    out_valid = (r_state == S_DONE);
  end

  // Divider datapath and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      if (w_div_start) begin
        r_rem     <= w_rem_next;
        r_quot    <= w_quot_next;
        r_divisor <= b;
        r_cnt     <= '0;
      end else begin
        r_result    <= w_fast_result;
        r_remainder <= w_fast_rem;
        r_dbz       <= w_fast_dbz;
      end
    end else if (r_state == S_CALC) begin
      r_rem  <= w_rem_next;
      r_quot <= w_quot_next;
      r_cnt  <= r_cnt + CW'(1);
      if (w_calc_last) begin
        r_result    <= {{WIDTH{1'b0}}, w_quot_next};
        r_remainder <= w_rem_next;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign result      = r_result;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit at WIDTH=4: directed vectors with literal
// expectations, an arithmetic reference model, and a per-cycle output monitor.
module tb_seq_arith_unit;

  localparam int W  = 4;
  localparam int RW = 2 * W;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic [W-1:0]  remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  // Expected values for the operation currently outstanding
  logic          exp_pending = 1'b0;
  logic [RW-1:0] exp_result  = '0;
  logic [W-1:0]  exp_rem     = '0;
  logic          exp_dbz     = 1'b0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [1:0] mop, output logic [RW-1:0] r,
                                output logic [W-1:0] rem, output logic dbz, output int lat);
    int ia;
    int ib;
    ia  = int'(ma);
    ib  = int'(mb);
    r   = '0;
    rem = '0;
    dbz = 1'b0;
    lat = 1;
    case (mop)
      ADD: r = RW'(ia + ib);
      SUB: r = RW'(ia - ib);
      MUL: r = RW'(ia * ib);
      default: begin
        if (ib == 0) begin
          r   = RW'((1 << W) - 1);
          rem = ma;
          dbz = 1'b1;
        end else begin
          r   = RW'(ia / ib);
          rem = W'(ia % ib);
          lat = W;
        end
      end
    endcase
  endfunction

  // Output monitor: any out_valid must carry the outstanding op's results
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_pending) begin
        check("mon_unexpected_out_valid", out_valid, 1'b0);
      end else begin
        check("mon_result", result, exp_result);
        check("mon_remainder", remainder, exp_rem);
        check("mon_div_by_zero", div_by_zero, exp_dbz);
      end
    end
  end

  // One operation with out_ready high, literal expectations pin the model
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top,
                        input logic [RW-1:0] lit_r, input logic [W-1:0] lit_rem,
                        input logic lit_dbz, input int lit_lat, input string name);
    logic [RW-1:0] mr;
    logic [W-1:0]  mrem;
    logic          mdbz;
    int            mlat;
    int            lat;
    model(ta, tb_, top, mr, mrem, mdbz, mlat);
    check({name, "_model_result"}, mr, lit_r);
    check({name, "_model_rem"}, mrem, lit_rem);
    check({name, "_model_dbz"}, mdbz, lit_dbz);
    check({name, "_model_lat"}, mlat, lit_lat);
    @(negedge clk);
    a = ta; b = tb_; op = top; in_valid = 1'b1; out_ready = 1'b1;
    check({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    exp_result = mr; exp_rem = mrem; exp_dbz = mdbz; exp_pending = 1'b1;
    #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; op = ~top;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({name, "_in_ready_busy"}, in_ready, 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, lit_lat);
    check({name, "_result"}, result, lit_r);
    check({name, "_remainder"}, remainder, lit_rem);
    check({name, "_div_by_zero"}, div_by_zero, lit_dbz);
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    check({name, "_out_valid_one_cycle"}, out_valid, 1'b0);
    check({name, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] mr;
    logic [W-1:0]  mrem;
    logic          mdbz;
    int            mlat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = ADD;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_remainder", remainder, '0);
    check("rst_div_by_zero", div_by_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_release", in_ready, 1'b1);

    // Single-cycle ops
    run_op(4'd10, 4'd5,  ADD, 8'd15,  4'd0, 1'b0, 1, "add_10_5");
    run_op(4'd8,  4'd2,  SUB, 8'd6,   4'd0, 1'b0, 1, "sub_8_2");
    run_op(4'd3,  4'd7,  SUB, 8'hFC,  4'd0, 1'b0, 1, "sub_3_7");
    run_op(4'd15, 4'd15, ADD, 8'd30,  4'd0, 1'b0, 1, "add_15_15");
    run_op(4'd15, 4'd15, MUL, 8'd225, 4'd0, 1'b0, 1, "mul_15_15");
    run_op(4'd0,  4'd15, SUB, 8'hF1,  4'd0, 1'b0, 1, "sub_0_15");

    // Iterative divide
    run_op(4'd7,  4'd3,  DIV, 8'd2,   4'd1, 1'b0, 4, "div_7_3");
    run_op(4'd10, 4'd5,  DIV, 8'd2,   4'd0, 1'b0, 4, "div_10_5");
    run_op(4'd3,  4'd9,  DIV, 8'd0,   4'd3, 1'b0, 4, "div_3_9");
    run_op(4'd15, 4'd1,  DIV, 8'd15,  4'd0, 1'b0, 4, "div_15_1");

    // Divide by zero
    run_op(4'd9,  4'd0,  DIV, 8'd15,  4'd9, 1'b1, 1, "div_9_0");

    // Asynchronous reset between edges clears held outputs at once
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", result, '0);
    check("async_rst_remainder", remainder, '0);
    check("async_rst_div_by_zero", div_by_zero, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: MUL 7*3 held in DONE for 5 cycles while a second op waits
    model(4'd7, 4'd3, MUL, mr, mrem, mdbz, mlat);
    check("bp_model_result", mr, 8'd21);
    @(negedge clk);
    a = 4'd7; b = 4'd3; op = MUL; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    exp_result = mr; exp_rem = mrem; exp_dbz = mdbz; exp_pending = 1'b1;
    #1;
    a = 4'd1; b = 4'd1; op = ADD; in_valid = 1'b1;
    check("bp_latency_out_valid", out_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1'b1);
      check("bp_result_held", result, 8'd21);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    check("bp_handshake_done", out_valid, 1'b0);
    check("bp_in_ready_return", in_ready, 1'b1);
    check("bp_result_kept", result, 8'd21);
    @(posedge clk);
    #1;
    check("bp_second_op_not_taken", out_valid, 1'b0);

    // Reset in the middle of a divide discards it
    @(negedge clk);
    a = 4'd15; b = 4'd2; op = DIV; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_result", result, '0);
    check("mid_rst_remainder", remainder, '0);
    check("mid_rst_div_by_zero", div_by_zero, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_out_valid_held_low", out_valid, 1'b0);
    end
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready_release", in_ready, 1'b1);
    run_op(4'd15, 4'd2, DIV, 8'd7, 4'd1, 1'b0, 4, "div_15_2_after_rst");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
